// File: rtl/osd_regaccess_master_pkg.sv
// DI flit type and register-access protocol constants shared by the
// register-access initiator and target.
package osd_regaccess_master_pkg;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam logic [1:0] TYPE_REG           = 2'b00;
  // Request subtype is {REQ_*, size}
  localparam logic [1:0] REQ_READ           = 2'b00;
  localparam logic [1:0] REQ_WRITE          = 2'b01;
  // Read success carries the access size in its low two bits
  localparam logic [3:0] RESP_READ_SUCCESS  = 4'b1000;
  localparam logic [3:0] RESP_READ_ERROR    = 4'b1100;
  localparam logic [3:0] RESP_WRITE_SUCCESS = 4'b1110;
  localparam logic [3:0] RESP_WRITE_ERROR   = 4'b1111;

  localparam logic [1:0] ACCESS_SIZE_16     = 2'b00;
  localparam logic [1:0] ACCESS_SIZE_32     = 2'b01;
  localparam logic [1:0] ACCESS_SIZE_64     = 2'b10;
  localparam logic [1:0] ACCESS_SIZE_128    = 2'b11;

  function automatic logic size_fits(input logic [1:0] size, input int max_bits);
    return (16 << size) <= max_bits;
  endfunction

endpackage

// File: rtl/osd_regaccess_master.sv
// Register-access initiator: serializes one local request into a DI request
// packet, then parses the matching DI response back into a completion.
module osd_regaccess_master
  import osd_regaccess_master_pkg::*;
#(
  parameter int MAX_REG_SIZE   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             id,
  output dii_flit                 debug_out,
  input  logic                    debug_out_ready,
  input  dii_flit                 debug_in,
  output logic                    debug_in_ready,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [15:0]             req_dest,
  input  logic [15:0]             req_addr,
  input  logic [1:0]              req_size,
  input  logic [MAX_REG_SIZE-1:0] req_wdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic                    resp_timeout,
  output logic [MAX_REG_SIZE-1:0] resp_rdata
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_TX_DEST, S_TX_SRC, S_TX_TYPE, S_TX_ADDR, S_TX_DATA,
    S_RX_DEST, S_RX_SRC, S_RX_TYPE, S_RX_DATA, S_RX_DROP, S_DONE
  } state_t;

  state_t                  r_state, w_nxt;
  logic                    r_write, r_drop, r_fin, r_err, r_tmo;
  logic [15:0]             r_dest, r_addr;
  logic [1:0]              r_size;
  logic [MAX_REG_SIZE-1:0] r_wdata, r_rdata;
  logic [3:0]              r_cnt;
  logic [TW-1:0]           r_tcnt;

  logic [3:0]  w_nwords, w_widx;
  logic [15:0] w_wword;
  logic [3:0]  w_sub;
  logic        w_last_word, w_tx, w_rx, w_hdr_ok, w_rd_data, w_sub_ok, w_sub_fail;
  logic        w_type_err, w_timeout;

  always_comb begin
    case (r_size)
      ACCESS_SIZE_16:  w_nwords = 4'd1;
      ACCESS_SIZE_32:  w_nwords = 4'd2;
      ACCESS_SIZE_64:  w_nwords = 4'd4;
      ACCESS_SIZE_128: w_nwords = 4'd8;
      default:         w_nwords = 4'd1;
    endcase
  end

  // r_cnt indexes data words on both the write and the read-data path
  assign w_last_word = (r_cnt == w_nwords - 4'd1);
  assign w_widx      = w_nwords - 4'd1 - r_cnt;
  assign w_wword     = 16'(r_wdata >> {w_widx, 4'b0000});

  assign w_tx       = debug_out.valid && debug_out_ready;
  assign w_rx       = debug_in.valid && debug_in_ready;
  assign w_sub      = debug_in.data[13:10];
  assign w_hdr_ok   = !r_drop && (debug_in.data[15:14] == TYPE_REG);
  assign w_rd_data  = !r_write && (w_sub == {RESP_READ_SUCCESS[3:2], r_size});
  assign w_sub_ok   = r_write ? (w_sub == RESP_WRITE_SUCCESS || w_sub == RESP_WRITE_ERROR)
                              : (w_rd_data || w_sub == RESP_READ_ERROR);
  assign w_sub_fail = (w_sub == RESP_WRITE_ERROR) || (w_sub == RESP_READ_ERROR);
  // Read data must not end on the type word; status replies must end there
  assign w_type_err = w_rd_data ? debug_in.last : (!w_sub_ok || w_sub_fail || !debug_in.last);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_tcnt == TMO_LAST);

  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_DONE);
  assign resp_err     = r_err;
  assign resp_timeout = r_tmo;
  assign resp_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt          = r_state;
    debug_out      = '0;
    debug_in_ready = 1'b0;
    case (r_state)
      S_IDLE:
        if (req_valid) w_nxt = size_fits(req_size, MAX_REG_SIZE) ? S_TX_DEST : S_DONE;
      S_TX_DEST: begin
        debug_out.valid = 1'b1;
        debug_out.data  = r_dest;
        if (debug_out_ready) w_nxt = S_TX_SRC;
      end
      S_TX_SRC: begin
        debug_out.valid = 1'b1;
        debug_out.data  = id;
        if (debug_out_ready) w_nxt = S_TX_TYPE;
      end
      S_TX_TYPE: begin
        debug_out.valid = 1'b1;
        debug_out.data  = {TYPE_REG, (r_write ? REQ_WRITE : REQ_READ), r_size, 10'h000};
        if (debug_out_ready) w_nxt = S_TX_ADDR;
      end
      S_TX_ADDR: begin
        debug_out.valid = 1'b1;
        debug_out.last  = !r_write;
        debug_out.data  = r_addr;
        if (debug_out_ready) w_nxt = r_write ? S_TX_DATA : S_RX_DEST;
      end
      S_TX_DATA: begin
        debug_out.valid = 1'b1;
        debug_out.last  = w_last_word;
        debug_out.data  = w_wword;
        if (debug_out_ready && w_last_word) w_nxt = S_RX_DEST;
      end
      S_RX_DEST: begin
        debug_in_ready = 1'b1;
        if (debug_in.valid)  w_nxt = debug_in.last ? S_RX_DEST : S_RX_SRC;
        else if (w_timeout)  w_nxt = S_DONE;
      end
      S_RX_SRC: begin
        debug_in_ready = 1'b1;
        if (debug_in.valid) w_nxt = debug_in.last ? S_RX_DEST : S_RX_TYPE;
      end
      S_RX_TYPE: begin
        debug_in_ready = 1'b1;
        if (debug_in.valid) begin
          if (!w_hdr_ok)                     w_nxt = debug_in.last ? S_RX_DEST : S_RX_DROP;
          else if (w_rd_data && !debug_in.last) w_nxt = S_RX_DATA;
          else                               w_nxt = debug_in.last ? S_DONE : S_RX_DROP;
        end
      end
      S_RX_DATA: begin
        debug_in_ready = 1'b1;
        if (debug_in.valid) begin
          if (debug_in.last)    w_nxt = S_DONE;
          else if (w_last_word) w_nxt = S_RX_DROP;
        end
      end
      S_RX_DROP: begin
        debug_in_ready = 1'b1;
        if (debug_in.valid && debug_in.last) w_nxt = r_fin ? S_DONE : S_RX_DEST;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_dest  <= '0;
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_drop  <= 1'b0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (req_valid) begin
            r_write <= req_write;
            r_dest  <= req_dest;
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= !size_fits(req_size, MAX_REG_SIZE);
            r_tmo   <= 1'b0;
          end
        S_TX_DEST, S_TX_SRC, S_TX_TYPE, S_TX_ADDR: r_tcnt <= '0;
        S_TX_DATA: begin
          r_tcnt <= '0;
          if (w_tx) r_cnt <= r_cnt + 4'd1;
        end
        S_RX_DEST:
          if (w_rx) r_drop <= (debug_in.data != id);
          else if (w_timeout) begin
            r_err <= 1'b1;
            r_tmo <= 1'b1;
          end else r_tcnt <= r_tcnt + TW'(1);
        S_RX_SRC:
          if (w_rx && debug_in.data != r_dest) r_drop <= 1'b1;
        S_RX_TYPE:
          if (w_rx) begin
            // r_fin marks a packet addressed to us: its end completes the request
            r_fin <= w_hdr_ok;
            r_cnt <= '0;
            if (w_hdr_ok) r_err <= w_type_err;
          end
        S_RX_DATA:
          if (w_rx) begin
            r_rdata <= (r_rdata << 16) | MAX_REG_SIZE'(debug_in.data);
            r_cnt   <= r_cnt + 4'd1;
            if (w_last_word != debug_in.last) r_err <= 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule
